in_channel_ctrl: RTL and testbench

IN_CHANNEL_CTRL -- requirements
Module: in_channel_ctrl

---
 rtl/in_channel_pkg.sv | 6 +
 rtl/in_channel_fifo.sv | 31 +++
 rtl/in_channel_ctrl.sv | 50 +++++
 tb/tb_in_channel_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/in_channel_pkg.sv
// in_channel_pkg: shared word width, default depth and word type for the input channel
package in_channel_pkg;
  localparam int MEM_WIDTH = 12;
  localparam int N_IN = 16;
  typedef logic [MEM_WIDTH-1:0] word_t;
endpackage

// File: rtl/in_channel_fifo.sv
// in_channel_fifo: circular word buffer with wrapping pointers and occupancy count
module in_channel_fifo import in_channel_pkg::*; #(
  parameter int W = MEM_WIDTH,
  parameter int N = N_IN
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         wdata,
  output logic [W-1:0]         rdata,
  output logic [$clog2(N):0]   count
);
  localparam int AW = $clog2(N);
  logic [W-1:0] mem [N];
  logic [AW-1:0] wptr, rptr;
  assign rdata = mem[rptr];
  always_ff @(posedge clock)
    if (push) mem[wptr] <= wdata;
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/in_channel_ctrl.sv
// in_channel_ctrl: input channel handshake, read response and size; IN_CHANNEL_UNDERFLOW_EN enables the sticky underflow flag
module in_channel_ctrl import in_channel_pkg::*; #(
  parameter int MemoryElementWidth = MEM_WIDTH,
  parameter int NIn = N_IN
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          src_valid,
  input  logic [MemoryElementWidth-1:0] src_data,
  output logic                          src_ready,
  input  logic                          rd_req,
  output logic [MemoryElementWidth-1:0] rd_data,
  output logic                          rd_valid,
  output logic [MemoryElementWidth-1:0] size,
  output logic                          underflow
);
  localparam int AW = $clog2(NIn);
  logic [AW:0] count;
  logic [MemoryElementWidth-1:0] head;
  logic push, pop;
  assign src_ready = count < (AW+1)'(NIn);
  assign push = src_valid && src_ready;
  assign pop = rd_req && count != '0;
  assign size = MemoryElementWidth'(count);
  in_channel_fifo #(.W(MemoryElementWidth), .N(NIn)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(src_data),
    .rdata(head),
    .count(count)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= head;
    end
  end
`ifdef IN_CHANNEL_UNDERFLOW_EN
  always_ff @(posedge clock)
    if (reset) underflow <= 1'b0;
    else if (rd_req && count == '0) underflow <= 1'b1;
`else
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_in_channel_ctrl.sv
// tb_in_channel_ctrl: randomized scoreboard bench for in_channel_ctrl against a queue model
module tb_in_channel_ctrl;
  import in_channel_pkg::*;
  localparam int N = N_IN;
`ifdef IN_CHANNEL_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif
  typedef struct {
    logic v;
    word_t d;
    logic uf;
    int sz;
    logic rdy;
  } exp_t;
  logic clock = 1'b0, reset = 1'b0, src_valid = 1'b0, rd_req = 1'b0;
  word_t src_data = '0;
  logic src_ready, rd_valid, underflow;
  word_t rd_data, size;
  word_t model[$];
  exp_t expq[$];
  word_t last_rd = '0;
  bit uf = 1'b0;
  int n_checks = 0, n_fail = 0;
  in_channel_ctrl dut (
    .clock(clock),
    .reset(reset),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .rd_req(rd_req),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .size(size),
    .underflow(underflow)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clock)
    if (expq.size() != 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, e.v});
      chk(e.v ? "rd_data" : "rd_data_hold", 32'(rd_data), 32'(e.d));
      chk("size", 32'(size), e.sz);
      chk("src_ready", {31'b0, src_ready}, {31'b0, e.rdy});
      chk("underflow", {31'b0, underflow}, {31'b0, e.uf});
    end
  task automatic step(input logic v, input word_t d, input logic r);
    exp_t e;
    bit acc, served;
    acc = v && model.size() < N;
    served = r && model.size() != 0;
    src_valid = v;
    src_data = d;
    rd_req = r;
    if (served) last_rd = model.pop_front();
    else if (r) uf = 1'b1;
    if (acc) model.push_back(d);
    e.v = served;
    e.d = last_rd;
    e.uf = UF_EN && uf;
    e.sz = model.size();
    e.rdy = model.size() < N;
    expq.push_back(e);
    @(posedge clock);
    #1;
    src_valid = 1'b0;
    rd_req = 1'b0;
  endtask
  task automatic do_reset(input logic v, input word_t d, input logic r);
    exp_t e;
    reset = 1'b1;
    src_valid = v;
    src_data = d;
    rd_req = r;
    model.delete();
    last_rd = '0;
    uf = 1'b0;
    e.v = 1'b0;
    e.d = '0;
    e.uf = 1'b0;
    e.sz = 0;
    e.rdy = 1'b1;
    expq.push_back(e);
    @(posedge clock);
    #1;
    reset = 1'b0;
    src_valid = 1'b0;
    rd_req = 1'b0;
  endtask
  initial begin
    do_reset(0, '0, 0);
    step(1, 12'd88, 0);
    step(1, 12'd44, 0);
    step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 0);
    for (int i = 1; i <= 16; i++) step(1, word_t'(i), 0);
    step(1, 12'd17, 0);
    step(0, '0, 1);
    step(0, '0, 0);
    do_reset(0, '0, 0);
    step(1, '0, 0);
    for (int i = 1; i < 40; i++) begin
      step(1, word_t'(i), 1);
      chk("stream_size_le1", {31'b0, size <= 1}, 32'd1);
    end
    step(0, '0, 1);
    step(0, '0, 0);
    step(1, 12'd7, 1);
    step(0, '0, 1);
    for (int i = 0; i < 5; i++) step(1, word_t'(100 + i), 0);
    step(0, '0, 0);
    do_reset(1, 12'd9, 1);
    step(0, '0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) do_reset($urandom_range(1), word_t'($urandom), $urandom_range(1));
      else step($urandom_range(2) != 0, word_t'($urandom), $urandom_range(1));
    end
    step(0, '0, 0);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
